matmul_sequencer: RTL and testbench



---
 rtl/matmul_pkg.sv | 57 +++++
 rtl/op_scoreboard.sv | 34 +++
 rtl/matmul_sequencer.sv | 146 ++++++++++++++
 tb/tb_matmul_sequencer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared encodings, address map and STATUS layout for the
// matrix-multiplier sequencer.
package matmul_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOADING = 3'd1,
      S_RUN     = 3'd2,
      S_DONE    = 3'd3,
      S_FAULT   = 3'd4
   } state_t;

   localparam int NUM_OPERANDS = 64;

   localparam logic [8:0] CTRL_ADDR   = 9'h100;
   localparam logic [8:0] STATUS_ADDR = 9'h101;
   localparam logic [8:0] RES_BASE    = 9'h140;

   localparam int CTRL_START   = 0;
   localparam int CTRL_ABORT   = 1;
   localparam int CTRL_IRQ_CLR = 2;
   localparam int CTRL_AUTO    = 3;

   localparam int ST_STATE_LSB = 0;
   localparam int ST_COUNT_LSB = 3;
   localparam int ST_DONE      = 10;
   localparam int ST_ERROR     = 11;
   localparam int ST_TIMEOUT   = 12;
   localparam int ST_OVERRUN   = 13;
   localparam int ST_AUTO      = 15;

   typedef struct packed {
      logic done;
      logic mm_err;
      logic timeout;
      logic overrun;
   } flags_t;

   function automatic logic [15:0] status_word(
      state_t     s,
      logic [6:0] cnt,
      flags_t     f,
      logic       auto_start
   );
      logic [15:0] w;
      w                      = '0;
      w[ST_STATE_LSB +: 3]   = s;
      w[ST_COUNT_LSB +: 7]   = cnt;
      w[ST_DONE]             = f.done;
      w[ST_ERROR]            = f.mm_err;
      w[ST_TIMEOUT]          = f.timeout;
      w[ST_OVERRUN]          = f.overrun;
      w[ST_AUTO]             = auto_start;
      return w;
   endfunction

endpackage

// File: rtl/op_scoreboard.sv
// Operand load tracker: 64-entry bitmap with an incremental
// population count that only moves on first writes.
module op_scoreboard
   import matmul_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       set,
   input  logic       clr,
   input  logic [5:0] idx,
   output logic [6:0] count,
   output logic [6:0] count_nxt
);

   logic [NUM_OPERANDS-1:0] loaded;
   logic                    fresh;

   assign fresh     = set && !loaded[idx];
   assign count_nxt = clr ? '0 : count + {6'd0, fresh};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         loaded <= '0;
         count  <= '0;
      end else if (clr) begin
         loaded <= '0;
         count  <= '0;
      end else if (fresh) begin
         loaded[idx] <= 1'b1;
         count       <= count_nxt;
      end
   end

endmodule

// File: rtl/matmul_sequencer.sv
// Host-bus sequencer for the 4x4 complex matrix multiplier:
// operand forwarding, start/abort control, completion supervision.
module matmul_sequencer
   import matmul_pkg::*;
#(
   parameter int Width         = 32,
   parameter int TimeoutCycles = 1024
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             write,
   input  logic             read,
   input  logic [8:0]       address,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic             irq,
   output logic             op_we,
   output logic [5:0]       op_index,
   output logic [Width-1:0] op_data,
   output logic             mm_start,
   output logic             mm_reset,
   input  logic             mm_listo,
   input  logic             mm_error,
   output logic [4:0]       res_index,
   input  logic [Width-1:0] res_data
);

   localparam int         TW   = $clog2(TimeoutCycles);
   localparam logic [6:0] FULL = 7'(NUM_OPERANDS);

   state_t         state;
   state_t         state_nxt;
   flags_t         flags;
   flags_t         flags_nxt;
   logic           auto_start;
   logic [TW-1:0]  tcnt;
   logic [6:0]     count;
   logic [6:0]     count_nxt;
   logic           op_wr;
   logic           ctrl_wr;
   logic           res_rd;
   logic           do_start;
   logic           do_abort;
   logic           do_clr;
   logic           sb_clr;
   logic           expired;
   logic [31:0]    rd_val;

   assign op_wr    = write && (address[8:6] == 3'b000);
   assign ctrl_wr  = write && (address == CTRL_ADDR);
   assign do_start = ctrl_wr && writedata[CTRL_START];
   assign do_abort = ctrl_wr && writedata[CTRL_ABORT];
   assign do_clr   = ctrl_wr && writedata[CTRL_IRQ_CLR];
   assign sb_clr   = do_abort || do_clr;
   assign expired  = (tcnt == TW'(TimeoutCycles - 1));

   // Operand path is blocked while the multiplier owns its register file.
   assign op_we    = op_wr && (state != S_RUN);
   assign op_index = op_we ? address[5:0] : '0;
   assign op_data  = op_we ? Width'(writedata) : '0;

   assign res_rd    = read && (address[8:5] == RES_BASE[8:5]);
   assign res_index = res_rd ? address[4:0] : '0;

   op_scoreboard u_sb (
      .clk       (clk),
      .reset_n   (reset_n),
      .set       (op_we),
      .clr       (sb_clr),
      .idx       (address[5:0]),
      .count     (count),
      .count_nxt (count_nxt)
   );

   always_comb begin
      state_nxt = state;
      flags_nxt = flags;
      if (sb_clr) begin
         state_nxt = S_IDLE;
         flags_nxt = '0;
      end else begin
         unique case (state)
            S_IDLE, S_LOADING: begin
               if (op_wr)
                  state_nxt = S_LOADING;
               if (do_start && (count_nxt != FULL))
                  flags_nxt.overrun = 1'b1;
               if ((count_nxt == FULL) && (do_start || auto_start))
                  state_nxt = S_RUN;
            end
            S_RUN: begin
               if (op_wr)
                  flags_nxt.overrun = 1'b1;
               // Completion beats a timeout landing in the same cycle.
               if (mm_listo) begin
                  if (mm_error) begin
                     state_nxt        = S_FAULT;
                     flags_nxt.mm_err = 1'b1;
                  end else begin
                     state_nxt      = S_DONE;
                     flags_nxt.done = 1'b1;
                  end
               end else if (expired) begin
                  state_nxt         = S_FAULT;
                  flags_nxt.timeout = 1'b1;
               end
            end
            S_DONE, S_FAULT: state_nxt = state;
            default:         state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      rd_val = '0;
      if (address == STATUS_ADDR)
         rd_val = {16'd0, status_word(state, count, flags, auto_start)};
      else if (res_rd)
         rd_val = 32'(res_data);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         flags      <= '0;
         auto_start <= 1'b0;
         tcnt       <= '0;
         irq        <= 1'b0;
         mm_start   <= 1'b0;
         mm_reset   <= 1'b0;
         readdata   <= '0;
      end else begin
         state    <= state_nxt;
         flags    <= flags_nxt;
         tcnt     <= (state == S_RUN) ? tcnt + 1'b1 : '0;
         irq      <= ((state == S_DONE) || (state == S_FAULT)) && !sb_clr;
         mm_start <= (state != S_RUN) && (state_nxt == S_RUN);
         mm_reset <= do_abort;
         if (ctrl_wr)
            auto_start <= writedata[CTRL_AUTO];
         if (read)
            readdata <= rd_val;
      end
   end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: cycle-level behavioural model with a
// per-cycle compare process, directed scenarios and random bus traffic.
module tb_matmul_sequencer;

   localparam int TOUT = 16;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        write = 1'b0;
   logic        read = 1'b0;
   logic [8:0]  address = '0;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic        irq;
   logic        op_we;
   logic [5:0]  op_index;
   logic [31:0] op_data;
   logic        mm_start;
   logic        mm_reset;
   logic        mm_listo = 1'b0;
   logic        mm_error = 1'b0;
   logic [4:0]  res_index;
   logic [31:0] res_data;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   // Behavioural model state
   int          m_state = 0;
   bit [63:0]   m_loaded = '0;
   bit          m_done = 0, m_err = 0, m_tout = 0, m_ovr = 0, m_auto = 0;
   int          m_run = 0;
   bit          m_irq = 0, m_start = 0, m_rst = 0;
   logic [31:0] m_rdata = '0;

   logic        c_we, c_rd;
   logic [31:0] wd;
   logic [5:0]  idx;
   int          r;
   int          ptr = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] res_fn(logic [4:0] i);
      return 32'hC0DE_0000 ^ (32'h1000_0001 * {27'd0, i});
   endfunction

   assign res_data = res_fn(res_index);

   matmul_sequencer #(.Width(32), .TimeoutCycles(TOUT)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .write     (write),
      .read      (read),
      .address   (address),
      .writedata (writedata),
      .readdata  (readdata),
      .irq       (irq),
      .op_we     (op_we),
      .op_index  (op_index),
      .op_data   (op_data),
      .mm_start  (mm_start),
      .mm_reset  (mm_reset),
      .mm_listo  (mm_listo),
      .mm_error  (mm_error),
      .res_index (res_index),
      .res_data  (res_data)
   );

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_read(logic [8:0] a, int cnt);
      logic [31:0] v;
      v = '0;
      if (a == 9'h101) begin
         v[2:0]  = m_state[2:0];
         v[9:3]  = cnt[6:0];
         v[10]   = m_done;
         v[11]   = m_err;
         v[12]   = m_tout;
         v[13]   = m_ovr;
         v[15]   = m_auto;
      end else if (a >= 9'h140 && a <= 9'h15F) begin
         v = res_fn(a[4:0]);
      end
      return v;
   endfunction

   task automatic model_reset();
      m_state = 0; m_loaded = '0; m_run = 0;
      m_done = 0; m_err = 0; m_tout = 0; m_ovr = 0; m_auto = 0;
      m_irq = 0; m_start = 0; m_rst = 0; m_rdata = '0;
   endtask

   // One clock edge of the specified behaviour, from pre-edge values.
   task automatic model_step();
      int cnt;
      bit is_op, is_ctrl, st_start, st_abort, st_clr;
      bit n_irq, n_start;
      if (!reset_n) begin
         model_reset();
         return;
      end
      cnt      = $countones(m_loaded);
      is_op    = write && (address < 9'h040);
      is_ctrl  = write && (address == 9'h100);
      st_start = is_ctrl && writedata[0];
      st_abort = is_ctrl && writedata[1];
      st_clr   = is_ctrl && writedata[2];
      if (read)
         m_rdata = exp_read(address, cnt);
      n_irq   = (m_state == 3 || m_state == 4) && !st_abort && !st_clr;
      n_start = 1'b0;
      if (st_abort || st_clr) begin
         m_state = 0; m_loaded = '0;
         m_done = 0; m_err = 0; m_tout = 0; m_ovr = 0;
      end else if (m_state <= 1) begin
         if (is_op) begin
            m_loaded[address[5:0]] = 1'b1;
            m_state = 1;
         end
         if (st_start && $countones(m_loaded) < 64)
            m_ovr = 1;
         if ($countones(m_loaded) == 64 && (st_start || m_auto)) begin
            m_state = 2; m_run = 0; n_start = 1'b1;
         end
      end else if (m_state == 2) begin
         m_run++;
         if (is_op) m_ovr = 1;
         if (mm_listo) begin
            if (mm_error) begin m_state = 4; m_err = 1; end
            else begin m_state = 3; m_done = 1; end
         end else if (m_run == TOUT) begin
            m_state = 4; m_tout = 1;
         end
      end else if (is_op) begin
         m_loaded[address[5:0]] = 1'b1;
      end
      if (is_ctrl) m_auto = writedata[3];
      m_irq   = n_irq;
      m_start = n_start;
      m_rst   = st_abort;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic wr(logic [8:0] a, logic [31:0] d);
      write = 1'b1; address = a; writedata = d;
      tick();
      write = 1'b0; address = '0; writedata = '0;
   endtask

   task automatic rd(logic [8:0] a);
      read = 1'b1; address = a;
      tick();
      read = 1'b0; address = '0;
   endtask

   task automatic idle(int n);
      repeat (n) tick();
   endtask

   function automatic logic [31:0] op_val(logic [5:0] i);
      case (i[5:4])
         2'd0:    return (i[3:2] == i[1:0]) ? 32'd1 : 32'd0;
         2'd1:    return 32'd0;
         default: return {28'd0, i[3:0]};
      endcase
   endfunction

   task automatic load_all();
      int ord[64];
      int j, t;
      for (int i = 0; i < 64; i++) ord[i] = i;
      for (int i = 63; i > 0; i--) begin
         j = $urandom_range(0, i);
         t = ord[i]; ord[i] = ord[j]; ord[j] = t;
      end
      for (int i = 0; i < 64; i++)
         wr(9'(ord[i]), op_val(6'(ord[i])));
   endtask

   // Per-cycle comparison against the model, mid-cycle.
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         c_we = write && (address < 9'h040) && (m_state != 2);
         c_rd = read && (address >= 9'h140) && (address <= 9'h15F);
         chk("op_we", 32'(op_we), 32'(c_we));
         chk("op_index", {26'd0, op_index}, c_we ? {26'd0, address[5:0]} : 32'd0);
         chk("op_data", op_data, c_we ? writedata : 32'd0);
         chk("res_index", {27'd0, res_index}, c_rd ? {27'd0, address[4:0]} : 32'd0);
         chk("irq", 32'(irq), 32'(m_irq));
         chk("mm_start", 32'(mm_start), 32'(m_start));
         chk("mm_reset", 32'(mm_reset), 32'(m_rst));
         chk("readdata", readdata, m_rdata);
      end
   end

   initial begin
      reset_n = 1'b0;
      idle(2);
      chk_en = 1'b1;
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_readdata", readdata, 32'd0);
      reset_n = 1'b1;
      idle(1);
      rd(9'h101);
      chk("rst_status", readdata, 32'd0);

      // Full load, explicit start, completion after a few cycles
      load_all();
      wr(9'h100, 32'h1);
      chk("a_start_pulse", 32'(mm_start), 32'd1);
      idle(1);
      chk("a_start_drop", 32'(mm_start), 32'd0);
      idle(8);
      mm_listo = 1'b1;
      tick();
      mm_listo = 1'b0;
      chk("a_irq_lag", 32'(irq), 32'd0);
      idle(1);
      chk("a_irq", 32'(irq), 32'd1);
      rd(9'h101);
      chk("a_status", readdata, 32'h0000_0603);
      rd(9'h140);
      chk("a_res0", readdata, 32'hC0DE_0000);
      wr(9'h100, 32'h4);
      chk("a_irq_clr", 32'(irq), 32'd0);
      rd(9'h101);
      chk("a_status_clr", readdata, 32'd0);

      // Auto-start on the 64th write, then operand write during RUN
      wr(9'h100, 32'h8);
      load_all();
      chk("c_auto_start", 32'(mm_start), 32'd1);
      write = 1'b1; address = 9'h005; writedata = 32'h1234_5678;
      #1;
      chk("c_run_op_we", 32'(op_we), 32'd0);
      tick();
      write = 1'b0; address = '0; writedata = '0;
      rd(9'h101);
      chk("c_status", readdata, 32'h0000_A202);
      wr(9'h100, 32'h2);
      chk("c_abort_rst", 32'(mm_reset), 32'd1);
      idle(1);
      chk("c_abort_rst_end", 32'(mm_reset), 32'd0);
      rd(9'h101);
      chk("c_status_abort", readdata, 32'd0);

      // 63 distinct operands (0x2A twice), early start, then timeout
      for (int i = 0; i < 64; i++)
         if (i != 16) wr(9'(i), 32'(i));
      wr(9'h02A, 32'hAA);
      wr(9'h100, 32'h1);
      chk("d_no_start", 32'(mm_start), 32'd0);
      rd(9'h101);
      chk("d_status63", readdata, 32'h0000_21F9);
      wr(9'h010, 32'h10);
      wr(9'h100, 32'h1);
      idle(14);
      rd(9'h101);
      chk("d_still_run", readdata, 32'h0000_2202);
      idle(1);
      chk("d_irq_lag", 32'(irq), 32'd0);
      idle(1);
      chk("d_irq", 32'(irq), 32'd1);
      rd(9'h101);
      chk("d_status_tout", readdata, 32'h0000_3204);
      wr(9'h100, 32'h4);
      chk("d_irq_clr", 32'(irq), 32'd0);
      rd(9'h101);
      chk("d_status_clr", readdata, 32'd0);

      // Completion with error
      load_all();
      wr(9'h100, 32'h1);
      idle(3);
      mm_listo = 1'b1; mm_error = 1'b1;
      tick();
      mm_listo = 1'b0; mm_error = 1'b0;
      idle(1);
      chk("e_irq", 32'(irq), 32'd1);
      rd(9'h101);
      chk("e_status", readdata, 32'h0000_0A04);
      wr(9'h100, 32'h4);

      // Completion in the same cycle as timeout expiry
      load_all();
      wr(9'h100, 32'h1);
      idle(15);
      mm_listo = 1'b1;
      tick();
      mm_listo = 1'b0;
      rd(9'h101);
      chk("f_status", readdata, 32'h0000_0603);
      wr(9'h100, 32'h4);

      // Asynchronous reset mid-RUN
      load_all();
      wr(9'h100, 32'h1);
      idle(2);
      rd(9'h101);
      chk("g_status_run", readdata, 32'h0000_0202);
      reset_n = 1'b0;
      model_reset();
      #2;
      chk("g_rst_readdata", readdata, 32'd0);
      chk("g_rst_irq", 32'(irq), 32'd0);
      chk("g_rst_start", 32'(mm_start), 32'd0);
      tick();
      reset_n = 1'b1;
      rd(9'h101);
      chk("g_status", readdata, 32'd0);

      // Abort in LOADING; mm_listo outside RUN is ignored
      for (int i = 0; i < 5; i++) wr(9'(i), 32'(i));
      mm_listo = 1'b1;
      idle(3);
      mm_listo = 1'b0;
      rd(9'h101);
      chk("h_status", readdata, 32'h0000_0029);
      wr(9'h100, 32'h2);
      chk("h_abort_rst", 32'(mm_reset), 32'd1);
      idle(1);
      chk("h_abort_rst_end", 32'(mm_reset), 32'd0);
      rd(9'h101);
      chk("h_status_abort", readdata, 32'd0);

      // Randomized bus traffic against the model
      for (int n = 0; n < 4000; n++) begin
         r = $urandom_range(0, 99);
         mm_listo = ($urandom_range(0, 19) == 0);
         mm_error = ($urandom_range(0, 3) == 0);
         if (r < 55) begin
            if ($urandom_range(0, 3) == 0) begin
               idx = 6'($urandom_range(0, 63));
            end else begin
               idx = 6'(ptr);
               ptr++;
            end
            write = 1'b1; address = {3'b000, idx}; writedata = $urandom;
         end else if (r < 67) begin
            wd = '0;
            wd[31:4] = 28'($urandom);
            wd[0] = 1'($urandom_range(0, 1));
            wd[1] = ($urandom_range(0, 24) == 0);
            wd[2] = (m_state >= 3) ? 1'($urandom_range(0, 1))
                                   : ($urandom_range(0, 39) == 0);
            wd[3] = ($urandom_range(0, 2) != 0);
            write = 1'b1; address = 9'h100; writedata = wd;
         end else if (r < 87) begin
            read = 1'b1;
            case ($urandom_range(0, 3))
               0:       address = 9'h101;
               1:       address = 9'h140 + 9'($urandom_range(0, 31));
               2:       address = 9'($urandom_range(0, 511));
               default: address = 9'h100;
            endcase
         end
         tick();
         write = 1'b0; read = 1'b0; address = '0; writedata = '0;
         mm_listo = 1'b0; mm_error = 1'b0;
      end

      idle(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
